// File: rtl/dac_ltc2624_pkg.sv
// Shared constants, state encoding and frame packing for the LTC2624 DAC driver.
package dac_ltc2624_pkg;

  localparam logic [3:0] CMD_WRITE        = 4'b0000;
  localparam logic [3:0] CMD_UPDATE       = 4'b0001;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] CMD_POWER_DOWN   = 4'b0100;
  localparam logic [3:0] CMD_NOP          = 4'b1111;

  localparam logic [3:0] ADDR_A   = 4'h0;
  localparam logic [3:0] ADDR_B   = 4'h1;
  localparam logic [3:0] ADDR_C   = 4'h2;
  localparam logic [3:0] ADDR_D   = 4'h3;
  localparam logic [3:0] ADDR_ALL = 4'hF;

  localparam int FRAME_BITS = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0]  cmd,
                                                         input logic [3:0]  addr,
                                                         input logic [11:0] data);
    return {8'h00, cmd, addr, data, 4'h0};
  endfunction

endpackage

// File: rtl/dac_ltc2624_if.sv
// Sample request handshake plus the DAC pin bundle, as seen by the capture logic and the driver.
interface dac_ltc2624_if;
  logic        start;
  logic [11:0] data;
  logic [3:0]  addr;
  logic [3:0]  cmd;
  logic        busy;
  logic        done;
  logic        DAC_CS;
  logic        sck;
  logic        DAC_MOSI;
  logic        DAC_CLR;

  modport master (
    output start, data, addr, cmd,
    input  busy, done, DAC_CS, sck, DAC_MOSI, DAC_CLR
  );

  modport slave (
    input  start, data, addr, cmd,
    output busy, done, DAC_CS, sck, DAC_MOSI, DAC_CLR
  );
endinterface

// File: rtl/dac_ltc2624_driver_spi_half_period_timer.sv
// Down-counter producing a one-cycle tick at the end of every CLK_DIV-cycle half-period.
module spi_half_period_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clock_in,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);
  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == '0);

  always_ff @(posedge clock_in) begin
    if (!rst_n || restart_i) begin
      cnt_q <= RELOAD;
    end else if (cnt_q == '0) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/dac_ltc2624_driver.sv
// SPI master sending one 32-bit LTC2624 frame per accepted start; owns DAC_CLR.
//   state      | meaning
//   ST_IDLE    | CS high, waiting for start
//   ST_SETUP   | CS low, bit 31 on MOSI, sck low for N cycles
//   ST_SHIFT   | 32 sck periods, data changes on falling sck
//   ST_HOLD    | CS low, sck low, MOSI low for N cycles
//   ST_RECOVER | CS high for N cycles, done in first cycle
module dac_ltc2624_driver
  import dac_ltc2624_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = 32
) (
  input  logic         clock_in,
  input  logic         rst_n,
  dac_ltc2624_if.slave bus
);
  state_e                state_q;
  logic [FRAME_BITS-1:0] shreg_q;
  logic [FRAME_BITS-1:0] frame_in;
  logic [4:0]            bit_cnt_q;
  logic                  cs_q, sck_q, mosi_q, busy_q, done_q, clr_q;
  logic                  tick;
  logic                  restart;

  // Idle keeps the timer loaded so the first half-period after start is exactly N cycles.
  assign restart  = (state_q == ST_IDLE);
  assign frame_in = build_frame(bus.cmd, bus.addr, bus.data);

  spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clock_in  (clock_in),
    .rst_n     (rst_n),
    .restart_i (restart),
    .tick_o    (tick)
  );

  always_ff @(posedge clock_in) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      clr_q  <= 1'b1;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            shreg_q <= frame_in;
            mosi_q  <= frame_in[FRAME_BITS-1];
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            sck_q     <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (sck_q) begin
              sck_q   <= 1'b0;
              shreg_q <= {shreg_q[FRAME_BITS-2:0], 1'b0};
              mosi_q  <= shreg_q[FRAME_BITS-2];
            end else if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
              mosi_q  <= 1'b0;
              state_q <= ST_HOLD;
            end else begin
              sck_q     <= 1'b1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (tick) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.DAC_CS   = cs_q;
  assign bus.sck      = sck_q;
  assign bus.DAC_MOSI = mosi_q;
  assign bus.DAC_CLR  = clr_q;
endmodule

// File: tb/tb_dac_ltc2624_driver.sv
// Directed bench for dac_ltc2624_driver: CLK_DIV=2 instance plus a CLK_DIV=1 instance.
module tb_dac_ltc2624_driver;
  import dac_ltc2624_pkg::*;

  logic clock_in = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clock_in = ~clock_in;

  dac_ltc2624_if b1();
  dac_ltc2624_if b2();

  dac_ltc2624_driver #(.CLK_DIV(2)) dut_n2 (.clock_in(clock_in), .rst_n(rst_n), .bus(b1));
  dac_ltc2624_driver #(.CLK_DIV(1)) dut_n1 (.clock_in(clock_in), .rst_n(rst_n), .bus(b2));

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] r_frm;
  int          r_rise, r_cslow, r_last_cs_low, r_done_at, r_done_cnt, r_busy_low;
  logic        r_cs_end, r_sck_end, r_clr_end;

  task automatic drive_in(input bit use2, input logic st, input logic [11:0] d,
                          input logic [3:0] a, input logic [3:0] c);
    if (use2) begin
      b2.start = st; b2.data = d; b2.addr = a; b2.cmd = c;
    end else begin
      b1.start = st; b1.data = d; b1.addr = a; b1.cmd = c;
    end
  endtask

  // Cycle 0 is the cycle whose closing edge samples start=1; inputs are scrambled afterwards.
  task automatic send(input bit use2, input bit now, input logic [11:0] d,
                      input logic [3:0] a, input logic [3:0] c);
    if (!now) @(negedge clock_in);
    drive_in(use2, 1'b1, d, a, c);
    @(posedge clock_in);
    #1;
    drive_in(use2, 1'b0, ~d, ~a, ~c);
  endtask

  // Samples cycles 1.. at negedge until busy drops; inj_kind 1 = extra start, 2 = reset pulse.
  task automatic observe(input bit use2, input int max_cyc, input int inj_cyc,
                         input int inj_kind, input logic [11:0] inj_data);
    logic prev_sck, s_cs, s_sck, s_mosi, s_done, s_busy, s_clr;
    prev_sck = 1'b0;
    r_frm = '0; r_rise = 0; r_cslow = 0; r_last_cs_low = -1;
    r_done_at = -1; r_done_cnt = 0; r_busy_low = -1;
    r_cs_end = 1'bx; r_sck_end = 1'bx; r_clr_end = 1'bx;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clock_in);
      s_cs   = use2 ? b2.DAC_CS   : b1.DAC_CS;
      s_sck  = use2 ? b2.sck      : b1.sck;
      s_mosi = use2 ? b2.DAC_MOSI : b1.DAC_MOSI;
      s_done = use2 ? b2.done     : b1.done;
      s_busy = use2 ? b2.busy     : b1.busy;
      s_clr  = use2 ? b2.DAC_CLR  : b1.DAC_CLR;
      if (!prev_sck && s_sck && !s_cs) begin
        r_frm  = {r_frm[30:0], s_mosi};
        r_rise = r_rise + 1;
      end
      prev_sck = s_sck;
      if (!s_cs) begin
        r_cslow = r_cslow + 1;
        r_last_cs_low = k;
      end
      if (s_done) begin
        r_done_cnt = r_done_cnt + 1;
        if (r_done_at < 0) r_done_at = k;
      end
      if (inj_kind == 1 && k == inj_cyc)     drive_in(use2, 1'b1, inj_data, ADDR_A, CMD_WRITE);
      if (inj_kind == 1 && k == inj_cyc + 1) drive_in(use2, 1'b0, 12'h000, ADDR_A, CMD_WRITE);
      if (inj_kind == 2 && k == inj_cyc)     rst_n = 1'b0;
      if (inj_kind == 2 && k == inj_cyc + 1) rst_n = 1'b1;
      if (!s_busy) begin
        r_busy_low = k;
        r_cs_end   = s_cs;
        r_sck_end  = s_sck;
        r_clr_end  = s_clr;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_in(0, 1'b0, 12'h000, ADDR_A, CMD_NOP);
    drive_in(1, 1'b0, 12'h000, ADDR_A, CMD_NOP);
    repeat (3) begin
      @(negedge clock_in);
      n_cmp++;
      if ({b1.DAC_CS, b1.sck, b1.busy, b1.done, b1.DAC_MOSI, b1.DAC_CLR} !== 6'b100000) begin
        n_bad++;
        $display("FAIL reset_n2 {cs,sck,busy,done,mosi,clr}: got %b want 100000",
                 {b1.DAC_CS, b1.sck, b1.busy, b1.done, b1.DAC_MOSI, b1.DAC_CLR});
      end
      n_cmp++;
      if ({b2.DAC_CS, b2.sck, b2.busy, b2.done, b2.DAC_MOSI, b2.DAC_CLR} !== 6'b100000) begin
        n_bad++;
        $display("FAIL reset_n1 {cs,sck,busy,done,mosi,clr}: got %b want 100000",
                 {b2.DAC_CS, b2.sck, b2.busy, b2.done, b2.DAC_MOSI, b2.DAC_CLR});
      end
    end
    rst_n = 1'b1;
    @(negedge clock_in);
    n_cmp++;
    if ({b1.DAC_CLR, b2.DAC_CLR, b1.DAC_CS, b1.busy} !== 4'b1110) begin
      n_bad++;
      $display("FAIL reset_release {clr_n2,clr_n1,cs,busy}: got %b want 1110",
               {b1.DAC_CLR, b2.DAC_CLR, b1.DAC_CS, b1.busy});
    end
  endtask

  task automatic test_basic_frame();
    send(0, 0, 12'hABC, ADDR_ALL, CMD_WRITE_UPDATE);
    observe(0, 400, 0, 0, 12'h000);
    n_cmp++;
    if (r_frm !== 32'h003FABC0) begin
      n_bad++; $display("FAIL basic_payload: got %h want 003fabc0", r_frm);
    end
    n_cmp++;
    if (r_rise !== 32) begin
      n_bad++; $display("FAIL basic_sck_rises: got %0d want 32", r_rise);
    end
    n_cmp++;
    if (r_cslow !== 132 || r_last_cs_low !== 132) begin
      n_bad++; $display("FAIL basic_cs_low: got %0d cycles ending %0d want 132 ending 132", r_cslow, r_last_cs_low);
    end
    n_cmp++;
    if (r_done_at !== 133 || r_done_cnt !== 1) begin
      n_bad++; $display("FAIL basic_done: got cycle %0d count %0d want cycle 133 count 1", r_done_at, r_done_cnt);
    end
    n_cmp++;
    if (r_busy_low !== 135) begin
      n_bad++; $display("FAIL basic_busy_low: got %0d want 135", r_busy_low);
    end
  endtask

  task automatic test_start_while_busy();
    int extra_cs, extra_done;
    send(0, 0, 12'h555, ADDR_B, CMD_WRITE);
    observe(0, 400, 40, 1, 12'h123);
    n_cmp++;
    if (r_frm !== 32'h00015550) begin
      n_bad++; $display("FAIL busy_payload: got %h want 00015550", r_frm);
    end
    n_cmp++;
    if (r_done_cnt !== 1 || r_busy_low !== 135) begin
      n_bad++; $display("FAIL busy_done: got count %0d busy low %0d want 1 and 135", r_done_cnt, r_busy_low);
    end
    extra_cs = 0;
    extra_done = 0;
    repeat (150) begin
      @(negedge clock_in);
      if (!b1.DAC_CS || b1.busy) extra_cs++;
      if (b1.done) extra_done++;
    end
    n_cmp++;
    if (extra_cs !== 0 || extra_done !== 0) begin
      n_bad++; $display("FAIL busy_no_second_frame: got active %0d done %0d want 0 0", extra_cs, extra_done);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    send(0, 0, 12'h000, ADDR_A, CMD_POWER_DOWN);
    observe(0, 400, 0, 0, 12'h000);
    gap = r_busy_low - r_last_cs_low;
    n_cmp++;
    if (r_frm !== 32'h00400000 || r_busy_low !== 135) begin
      n_bad++; $display("FAIL b2b_first: got %h busy low %0d want 00400000 135", r_frm, r_busy_low);
    end
    send(0, 1, 12'hFFF, ADDR_D, CMD_NOP);
    observe(0, 400, 0, 0, 12'h000);
    n_cmp++;
    if (r_frm !== 32'h00F3FFF0) begin
      n_bad++; $display("FAIL b2b_second: got %h want 00f3fff0", r_frm);
    end
    n_cmp++;
    if (r_done_at !== 133 || r_busy_low !== 135) begin
      n_bad++; $display("FAIL b2b_second_timing: got done %0d busy low %0d want 133 135", r_done_at, r_busy_low);
    end
    n_cmp++;
    if (gap !== 3) begin
      n_bad++; $display("FAIL b2b_cs_gap: got %0d want 3", gap);
    end
  endtask

  task automatic test_reset_mid_frame();
    send(0, 0, 12'h555, ADDR_B, CMD_WRITE_UPDATE);
    observe(0, 400, 50, 2, 12'h000);
    n_cmp++;
    if (r_busy_low !== 51) begin
      n_bad++; $display("FAIL midrst_busy_low: got %0d want 51", r_busy_low);
    end
    n_cmp++;
    if ({r_cs_end, r_sck_end, r_clr_end} !== 3'b100) begin
      n_bad++; $display("FAIL midrst_pins {cs,sck,clr}: got %b want 100", {r_cs_end, r_sck_end, r_clr_end});
    end
    n_cmp++;
    if (r_done_cnt !== 0) begin
      n_bad++; $display("FAIL midrst_no_done: got %0d want 0", r_done_cnt);
    end
    send(0, 0, 12'h7E1, ADDR_C, CMD_WRITE_UPDATE);
    observe(0, 400, 0, 0, 12'h000);
    n_cmp++;
    if (r_frm !== 32'h00327E10 || r_rise !== 32) begin
      n_bad++; $display("FAIL midrst_next_frame: got %h rises %0d want 00327e10 32", r_frm, r_rise);
    end
    n_cmp++;
    if (r_cslow !== 132 || r_done_at !== 133 || r_busy_low !== 135) begin
      n_bad++; $display("FAIL midrst_next_timing: got cs %0d done %0d busy %0d want 132 133 135",
                        r_cslow, r_done_at, r_busy_low);
    end
  endtask

  task automatic test_clk_div_1();
    send(1, 0, 12'h801, ADDR_C, CMD_WRITE_UPDATE);
    observe(1, 200, 0, 0, 12'h000);
    n_cmp++;
    if (r_frm !== 32'h00328010 || r_rise !== 32) begin
      n_bad++; $display("FAIL div1_payload: got %h rises %0d want 00328010 32", r_frm, r_rise);
    end
    n_cmp++;
    if (r_cslow !== 66) begin
      n_bad++; $display("FAIL div1_cs_low: got %0d want 66", r_cslow);
    end
    n_cmp++;
    if (r_done_at !== 67 || r_done_cnt !== 1 || r_busy_low !== 68) begin
      n_bad++; $display("FAIL div1_done_busy: got done %0d x%0d busy low %0d want 67 x1 68",
                        r_done_at, r_done_cnt, r_busy_low);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_clk_div_1();
    repeat (4) @(negedge clock_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
